calib_pattern_gen: RTL and testbench

Responder to the calibration controller's bit-select handshake. On each `led_addr_bit_sel_start_in` pulse it streams one frame to the LED strip driver. In that frame, LED *i* shows `ON_COLOR` when bit `led_addr_bit_sel_in` of *i* is set and `OFF_COLOR` otherwise. After the driver latches the frame and a camera settle interval elapses, it returns a one-cycle `led_display_valid_out`, which feeds the controller's `led_display_valid_in`.

---
 rtl/calib_pattern_gen_pkg.sv | 20 ++
 rtl/calib_pattern_gen_settle_timer.sv | 27 ++
 rtl/calib_pattern_gen.sv | 135 +++++++++++++
 tb/tb_calib_pattern_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calib_pattern_gen_pkg.sv
// Shared calibration types: pattern generator state encoding
// and the default LED colors for lit and dark positions.
`ifndef CALIB_PATTERN_GEN_PKG_SV
`define CALIB_PATTERN_GEN_PKG_SV

package calib_pattern_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_LATCH,
        SETTLE
    } calib_pattern_state_t;

    localparam logic [23:0] CALIB_ON_COLOR  = 24'hFFFFFF;
    localparam logic [23:0] CALIB_OFF_COLOR = 24'h000000;

endpackage

`endif

// File: rtl/calib_pattern_gen_settle_timer.sv
// Loadable down-counter timing the camera settle interval.
// done_out is high whenever the count has reached zero.
module settle_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_value_in,
    output logic             done_out
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count <= '0;
        end else if (load_in) begin
            count <= load_value_in;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done_out = (count == '0);

endmodule

// File: rtl/calib_pattern_gen.sv
// Streams one bit-select calibration frame to the LED driver, then
// reports a settled display once the strip latches and settles.
module calib_pattern_gen
    import calib_pattern_gen_pkg::*;
#(
    parameter int unsigned NUM_LEDS               = 50,
    parameter int unsigned LED_ADDRESS_WIDTH      = $clog2(NUM_LEDS),
    parameter int unsigned LED_ADDR_BIT_SEL_WIDTH = $clog2(LED_ADDRESS_WIDTH),
    parameter int unsigned COLOR_WIDTH            = 24,
    parameter logic [COLOR_WIDTH-1:0] ON_COLOR    = COLOR_WIDTH'(CALIB_ON_COLOR),
    parameter logic [COLOR_WIDTH-1:0] OFF_COLOR   = COLOR_WIDTH'(CALIB_OFF_COLOR),
    parameter int unsigned SETTLE_CYCLES          = 2_000_000
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [LED_ADDR_BIT_SEL_WIDTH-1:0] led_addr_bit_sel_in,
    input  logic                              led_addr_bit_sel_start_in,
    output logic [COLOR_WIDTH-1:0]            color_out,
    output logic [LED_ADDRESS_WIDTH-1:0]      led_index_out,
    output logic                              color_valid_out,
    input  logic                              color_ready_in,
    output logic                              last_out,
    input  logic                              frame_done_in,
    output logic                              led_display_valid_out,
    output logic                              busy_out
);

    localparam int unsigned SETTLE_CW =
        (SETTLE_CYCLES == 0) ? 1 : $clog2(SETTLE_CYCLES + 1);
    // Loading S-1 makes the pulse land S+1 cycles after frame_done.
    localparam int unsigned SETTLE_LOAD =
        (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
    localparam logic [LED_ADDRESS_WIDTH-1:0] LAST_IDX =
        LED_ADDRESS_WIDTH'(NUM_LEDS - 1);

    calib_pattern_state_t                state;
    logic [LED_ADDR_BIT_SEL_WIDTH-1:0]   sel_q;
    logic                                timer_load;
    logic                                timer_done;
    logic [LED_ADDRESS_WIDTH-1:0]        next_idx;

    // Loop compare keeps out-of-range selects from indexing the index.
    function automatic logic [COLOR_WIDTH-1:0] pick_color(
        input logic [LED_ADDRESS_WIDTH-1:0]      idx,
        input logic [LED_ADDR_BIT_SEL_WIDTH-1:0] sel
    );
        logic lit;
        lit = 1'b0;
        for (int b = 0; b < int'(LED_ADDRESS_WIDTH); b++) begin
            if (int'(sel) == b) begin
                lit = idx[b];
            end
        end
        return lit ? ON_COLOR : OFF_COLOR;
    endfunction

    always_comb begin
        timer_load = (state == WAIT_LATCH) && frame_done_in &&
                     !led_addr_bit_sel_start_in;
        next_idx   = led_index_out + 1'b1;
    end

    settle_timer #(
        .WIDTH(SETTLE_CW)
    ) u_settle_timer (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .load_in      (timer_load),
        .load_value_in(SETTLE_CW'(SETTLE_LOAD)),
        .done_out     (timer_done)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state                 <= IDLE;
            sel_q                 <= '0;
            color_out             <= '0;
            led_index_out         <= '0;
            color_valid_out       <= 1'b0;
            last_out              <= 1'b0;
            led_display_valid_out <= 1'b0;
            busy_out              <= 1'b0;
        end else begin
            led_display_valid_out <= 1'b0;
            if (led_addr_bit_sel_start_in) begin
                state           <= STREAM;
                sel_q           <= led_addr_bit_sel_in;
                led_index_out   <= '0;
                color_out       <= pick_color('0, led_addr_bit_sel_in);
                color_valid_out <= 1'b1;
                last_out        <= (LAST_IDX == '0);
                busy_out        <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        busy_out <= 1'b0;
                    end
                    STREAM: begin
                        if (color_valid_out && color_ready_in) begin
                            if (led_index_out == LAST_IDX) begin
                                color_valid_out <= 1'b0;
                                last_out        <= 1'b0;
                                state           <= WAIT_LATCH;
                            end else begin
                                led_index_out <= next_idx;
                                color_out     <= pick_color(next_idx, sel_q);
                                last_out      <= (next_idx == LAST_IDX);
                            end
                        end
                    end
                    WAIT_LATCH: begin
                        if (frame_done_in) begin
                            if (SETTLE_CYCLES == 0) begin
                                led_display_valid_out <= 1'b1;
                                busy_out              <= 1'b0;
                                state                 <= IDLE;
                            end else begin
                                state <= SETTLE;
                            end
                        end
                    end
                    SETTLE: begin
                        if (timer_done) begin
                            led_display_valid_out <= 1'b1;
                            busy_out              <= 1'b0;
                            state                 <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calib_pattern_gen.sv
// Scoreboard bench: one DUT with a 4-cycle settle, one with zero
// settle, sharing stimulus; transfers and pulses checked by a monitor.
module tb_calib_pattern_gen;

    typedef struct {
        int          idx;
        logic [23:0] color;
        logic        last;
    } xfer_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [2:0]  sel = 3'd0;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic        fd = 1'b0;

    logic [23:0] color4, color0;
    logic [5:0]  idx4, idx0;
    logic        valid4, valid0, last4, last0, dv4, dv0, busy4, busy0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int xfer_cnt = 0;

    xfer_t exp_q[$];
    int    dv4_q[$];
    int    dv0_q[$];

    calib_pattern_gen #(.SETTLE_CYCLES(4)) dut4 (
        .clk_in                   (clk_in),
        .rst_n_in                 (rst_n_in),
        .led_addr_bit_sel_in      (sel),
        .led_addr_bit_sel_start_in(start),
        .color_out                (color4),
        .led_index_out            (idx4),
        .color_valid_out          (valid4),
        .color_ready_in           (ready),
        .last_out                 (last4),
        .frame_done_in            (fd),
        .led_display_valid_out    (dv4),
        .busy_out                 (busy4)
    );

    calib_pattern_gen #(.SETTLE_CYCLES(0)) dut0 (
        .clk_in                   (clk_in),
        .rst_n_in                 (rst_n_in),
        .led_addr_bit_sel_in      (sel),
        .led_addr_bit_sel_start_in(start),
        .color_out                (color0),
        .led_index_out            (idx0),
        .color_valid_out          (valid0),
        .color_ready_in           (ready),
        .last_out                 (last0),
        .frame_done_in            (fd),
        .led_display_valid_out    (dv0),
        .busy_out                 (busy0)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    always @(negedge clk_in) begin
        if (rst_n_in === 1'b1) begin
            if (valid4 && ready) begin
                xfer_t e;
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("xfer_unexpected_idx", idx4, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_idx", idx4, e.idx);
                    chk("xfer_color", color4, e.color);
                    chk("xfer_last", last4, e.last);
                end
            end
            if (dv4_q.size() != 0 && dv4_q[0] < cyc) begin
                chk("dv4_missed_cycle", cyc, dv4_q.pop_front());
            end
            if (dv4) begin
                if (dv4_q.size() != 0 && dv4_q[0] == cyc) begin
                    void'(dv4_q.pop_front());
                    chk("dv4_busy_fall", busy4, 0);
                end else begin
                    chk("dv4_unexpected_cycle", cyc, 32'hFFFF_FFFF);
                end
            end
            if (dv0_q.size() != 0 && dv0_q[0] < cyc) begin
                chk("dv0_missed_cycle", cyc, dv0_q.pop_front());
            end
            if (dv0) begin
                if (dv0_q.size() != 0 && dv0_q[0] == cyc) begin
                    void'(dv0_q.pop_front());
                    chk("dv0_busy_fall", busy0, 0);
                end else begin
                    chk("dv0_unexpected_cycle", cyc, 32'hFFFF_FFFF);
                end
            end
        end
    end

    task automatic issue_start(input int s);
        xfer_t e;
        exp_q.delete();
        for (int i = 0; i < 50; i++) begin
            e.idx   = i;
            e.color = (s < 6 && ((i >> s) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
            e.last  = (i == 49);
            exp_q.push_back(e);
        end
        xfer_cnt = 0;
        sel = 3'(s);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_valid", valid4, 1);
        chk("start_idx", idx4, 0);
        chk("start_busy", busy4, 1);
    endtask

    task automatic wait_frame(input int exp_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || valid4) && n < 200) begin
            tick();
            n++;
        end
        chk("frame_queue_left", exp_q.size(), 0);
        chk("frame_valid_low", valid4, 0);
        chk("frame_xfers", xfer_cnt, 50);
        if (exp_cycles > 0) chk("frame_cycles", n, exp_cycles);
    endtask

    task automatic done_pulse(input bit e4, input bit e0);
        if (e4) dv4_q.push_back(cyc + 1 + 4);
        if (e0) dv0_q.push_back(cyc + 1);
        fd = 1'b1;
        tick();
        fd = 1'b0;
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (idx4 != 6'(target) && n < 100) begin
            tick();
            n++;
        end
        chk("reach_idx", idx4, target);
    endtask

    initial begin
        rst_n_in = 1'b1;
        #1 rst_n_in = 1'b0;
        #2;
        chk("rst_valid", valid4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_dv", dv4, 0);
        chk("rst_color", color4, 0);
        repeat (2) tick();
        rst_n_in = 1'b1;
        tick();
        chk("post_rst_idx", idx4, 0);
        chk("post_rst_last", last4, 0);

        // bit-select 0, ready held high
        issue_start(0);
        wait_frame(50);
        done_pulse(1, 1);
        repeat (8) tick();
        chk("idle_busy", busy4, 0);

        // bit-select 2
        issue_start(2);
        wait_frame(50);
        done_pulse(1, 1);
        repeat (8) tick();

        // backpressure on bit-select 1
        issue_start(1);
        wait_idx(10);
        ready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_hold_idx", idx4, 10);
            chk("bp_hold_color", color4, 24'hFFFFFF);
            chk("bp_hold_valid", valid4, 1);
        end
        ready = 1'b1;
        wait_frame(0);
        done_pulse(1, 1);
        repeat (8) tick();

        // stray done during stream, then restart at index 20
        issue_start(0);
        wait_idx(5);
        fd = 1'b1;
        tick();
        fd = 1'b0;
        wait_idx(20);
        ready = 1'b0;
        issue_start(3);
        ready = 1'b1;
        wait_frame(50);
        done_pulse(1, 1);
        repeat (8) tick();

        // out-of-range bit-select
        issue_start(6);
        wait_frame(50);
        done_pulse(1, 1);
        repeat (8) tick();

        // restart while settling abandons the pending pulse
        issue_start(4);
        wait_frame(50);
        done_pulse(0, 1);
        repeat (2) tick();
        issue_start(5);
        wait_frame(50);
        done_pulse(1, 1);
        repeat (8) tick();

        // reset mid-settle
        issue_start(0);
        wait_frame(50);
        done_pulse(0, 1);
        repeat (2) tick();
        rst_n_in = 1'b0;
        #1;
        chk("arst_busy", busy4, 0);
        chk("arst_color", color4, 0);
        chk("arst_idx", idx4, 0);
        chk("arst_valid", valid4, 0);
        chk("arst_last", last4, 0);
        chk("arst_dv", dv4, 0);
        repeat (2) tick();
        rst_n_in = 1'b1;
        repeat (10) tick();
        chk("post_arst_busy", busy4, 0);
        chk("post_arst_valid", valid4, 0);

        chk("dv4_pending", dv4_q.size(), 0);
        chk("dv0_pending", dv0_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
